// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 and opcode
// encodings, the handshake FSM state type and the illegal W-variant combinations.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        F3Mul    = 3'd0,
        F3Mulh   = 3'd1,
        F3Mulhsu = 3'd2,
        F3Mulhu  = 3'd3,
        F3Div    = 3'd4,
        F3Divu   = 3'd5,
        F3Rem    = 3'd6,
        F3Remu   = 3'd7
    } funct3_m_e;

    typedef enum logic [6:0] {
        OpcOp   = 7'b0110011,
        OpcOp32 = 7'b0111011
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } muldiv_state_e;

    // One bit per funct3: set where the W form does not exist (MULH, MULHSU, MULHU).
    localparam logic [7:0] WordIllegalMask = 8'b0000_1110;

    function automatic logic word_illegal(logic [2:0] funct3);
        return WordIllegalMask[funct3];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 datapath: shift-add multiply, restoring divide, sign fix-up
// and the special-case bypass for divide-by-zero and signed overflow.
module muldiv_iter
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            idle,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    logic            word_eff, is_div, signed_a, signed_b, neg_a, neg_b;
    logic            b_zero, a_min, b_m1, overflow, special;
    logic [XLEN-1:0] a_s, a_z, b_s, b_z, mag_a, mag_b, special_res;

    logic [CntW-1:0]   cnt_q;
    logic [XLEN-1:0]   sh_q, opb_q, special_res_q;
    logic [2*XLEN-1:0] acc_q;
    logic              is_div_q, want_hi_q, want_rem_q, word_q, neg_q_q, neg_r_q, special_q;

    logic              msb, q_bit;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic [2*XLEN-1:0] acc_mul, prod;
    logic [XLEN-1:0]   quo, rmd, raw;

    // Operand preparation at accept: magnitudes, signs and bypass detection.
    always_comb begin
        word_eff = (XLEN == 64) && word && !word_illegal(funct3);
        is_div   = funct3[2];
        signed_a = is_div ? !funct3[0] : (funct3 == F3Mulh || funct3 == F3Mulhsu);
        signed_b = is_div ? !funct3[0] : (funct3 == F3Mulh);
        a_s      = word_eff ? sext32(a[31:0]) : a;
        a_z      = word_eff ? XLEN'(a[31:0]) : a;
        b_s      = word_eff ? sext32(b[31:0]) : b;
        b_z      = word_eff ? XLEN'(b[31:0]) : b;
        neg_a    = signed_a && a_s[XLEN-1];
        neg_b    = signed_b && b_s[XLEN-1];
        mag_a    = signed_a ? (neg_a ? -a_s : a_s) : a_z;
        mag_b    = signed_b ? (neg_b ? -b_s : b_s) : b_z;
        b_zero   = (b_z == '0);
        a_min    = word_eff ? (a[31:0] == 32'h8000_0000) : (a == {1'b1, {(XLEN-1){1'b0}}});
        b_m1     = word_eff ? (b[31:0] == 32'hFFFF_FFFF) : (b == '1);
        overflow = is_div && signed_a && a_min && b_m1;
        special  = is_div && (b_zero || overflow);
        special_res = '0;
        if (b_zero) begin
            special_res = funct3[1] ? a_s : '1;
        end else if (overflow) begin
            special_res = funct3[1] ? '0 : a_s;
        end
    end

    // One iteration step plus the final sign fix-up and result selection.
    always_comb begin
        msb     = word_q ? sh_q[31] : sh_q[XLEN-1];
        rem_sh  = {acc_q[XLEN-1:0], msb};
        rem_sub = rem_sh - {1'b0, opb_q};
        q_bit   = !rem_sub[XLEN];
        acc_mul = {acc_q[2*XLEN-2:0], 1'b0} + (msb ? {{XLEN{1'b0}}, opb_q} : '0);
        prod    = neg_q_q ? -acc_q : acc_q;
        quo     = neg_q_q ? -sh_q : sh_q;
        rmd     = neg_r_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        if (is_div_q) begin
            raw = want_rem_q ? rmd : quo;
        end else begin
            raw = want_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
        if (special_q) begin
            result = special_res_q;
        end else begin
            result = word_q ? sext32(raw[31:0]) : raw;
        end
        idle = (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            sh_q          <= '0;
            opb_q         <= '0;
            acc_q         <= '0;
            special_res_q <= '0;
            is_div_q      <= 1'b0;
            want_hi_q     <= 1'b0;
            want_rem_q    <= 1'b0;
            word_q        <= 1'b0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            special_q     <= 1'b0;
        end else if (clear) begin
            cnt_q     <= '0;
            special_q <= 1'b0;
        end else if (start) begin
            cnt_q         <= special ? '0 : (word_eff ? CntW'(32) : CntW'(XLEN));
            sh_q          <= mag_a;
            opb_q         <= mag_b;
            acc_q         <= '0;
            special_res_q <= special_res;
            special_q     <= special;
            is_div_q      <= is_div;
            want_hi_q     <= !is_div && (funct3[1:0] != 2'b00);
            want_rem_q    <= funct3[1];
            word_q        <= word_eff;
            neg_q_q       <= neg_a ^ neg_b;
            neg_r_q       <= neg_a;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
            if (is_div_q) begin
                acc_q <= {{XLEN{1'b0}}, (q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0])};
                sh_q  <= {sh_q[XLEN-2:0], q_bit};
            end else begin
                acc_q <= acc_mul;
                sh_q  <= {sh_q[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// M-extension multiply/divide unit: valid/ready handshake FSM around the
// iterative muldiv_iter datapath, with flush and pass-through tag.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    muldiv_state_e    state_q;
    logic [TAG_W-1:0] tag_q, out_tag_q;
    logic [XLEN-1:0]  out_result_q;
    logic             accept, iter_idle;
    logic [XLEN-1:0]  iter_result;

    // Flush wins over a simultaneous accept.
    assign accept = in_valid && (state_q == StIdle) && !flush;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (flush),
        .start  (accept),
        .funct3 (in_funct3),
        .word   (in_word),
        .a      (in_a),
        .b      (in_b),
        .idle   (iter_idle),
        .result (iter_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            out_tag_q    <= '0;
            out_result_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StBusy;
                        tag_q   <= in_tag;
                    end
                end
                StBusy: begin
                    if (iter_idle) begin
                        state_q      <= StDone;
                        out_result_q <= iter_result;
                        out_tag_q    <= tag_q;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: one XLEN=32 and one XLEN=64 instance.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        flush32 = 0, in_valid32 = 0, in_word32 = 0, out_ready32 = 0;
    logic        in_ready32, out_valid32;
    logic [2:0]  in_funct3_32 = 0;
    logic [31:0] in_a32 = 0, in_b32 = 0, out_result32;
    logic [4:0]  in_tag32 = 0, out_tag32;

    logic        flush64 = 0, in_valid64 = 0, in_word64 = 0, out_ready64 = 0;
    logic        in_ready64, out_valid64;
    logic [2:0]  in_funct3_64 = 0;
    logic [63:0] in_a64 = 0, in_b64 = 0, out_result64;
    logic [4:0]  in_tag64 = 0, out_tag64;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_funct3(in_funct3_32), .in_word(in_word32), .in_a(in_a32), .in_b(in_b32),
        .in_tag(in_tag32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_result(out_result32), .out_tag(out_tag32)
    );

    muldiv_unit #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_funct3(in_funct3_64), .in_word(in_word64), .in_a(in_a64), .in_b(in_b64),
        .in_tag(in_tag64), .out_valid(out_valid64), .out_ready(out_ready64),
        .out_result(out_result64), .out_tag(out_tag64)
    );

    // Issue one op, count edges after the accept edge until out_valid, then consume it.
    task automatic run32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res,
                         output logic [4:0] rtag, output int lat);
        @(negedge clk);
        in_valid32 = 1; in_funct3_32 = f3; in_a32 = a; in_b32 = b; in_tag32 = tag;
        @(posedge clk); #1;
        in_valid32 = 0; in_a32 = 32'hA5A5_5A5A; in_b32 = 32'h0; in_tag32 = 5'h1F;
        in_funct3_32 = 3'd7;
        lat = 0;
        while (out_valid32 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = out_result32; rtag = out_tag32;
        @(negedge clk); out_ready32 = 1;
        @(posedge clk); #1; out_ready32 = 0;
    endtask

    task automatic run64(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, output logic [63:0] res,
                         output logic [4:0] rtag, output int lat);
        @(negedge clk);
        in_valid64 = 1; in_funct3_64 = f3; in_word64 = w; in_a64 = a; in_b64 = b;
        in_tag64 = tag;
        @(posedge clk); #1;
        in_valid64 = 0; in_a64 = 64'h5A5A_A5A5_1234_5678; in_b64 = 64'h0; in_word64 = 0;
        in_tag64 = 5'h1F; in_funct3_64 = 3'd7;
        lat = 0;
        while (out_valid64 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = out_result64; rtag = out_tag64;
        @(negedge clk); out_ready64 = 1;
        @(posedge clk); #1; out_ready64 = 0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset_out_valid32 got %b want 0", out_valid32); end
        total++; if (out_result32 !== 32'h0) begin bad++; $display("FAIL reset_result32 got %h want 0", out_result32); end
        total++; if (out_tag32 !== 5'h0) begin bad++; $display("FAIL reset_tag32 got %h want 0", out_tag32); end
        total++; if (out_valid64 !== 1'b0) begin bad++; $display("FAIL reset_out_valid64 got %b want 0", out_valid64); end
        @(negedge clk); rst_n = 1;
        #1;
        total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset_in_ready32 got %b want 1", in_ready32); end
        total++; if (in_ready64 !== 1'b1) begin bad++; $display("FAIL reset_in_ready64 got %b want 1", in_ready64); end
    endtask

    task automatic test_mul;
        logic [2:0]  f3 [5] = '{F3Mul, F3Mulhu, F3Mulh, F3Mulh, F3Mulhsu};
        logic [31:0] va [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] vb [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] ex [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run32(f3[i], va[i], vb[i], 5'(i + 1), res, rtag, lat);
            total++; if (res !== ex[i]) begin bad++; $display("FAIL mul32[%0d] result got %h want %h", i, res, ex[i]); end
            total++; if (rtag !== 5'(i + 1)) begin bad++; $display("FAIL mul32[%0d] tag got %0d want %0d", i, rtag, i + 1); end
            total++; if (lat != 33) begin bad++; $display("FAIL mul32[%0d] latency got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3 [9] = '{F3Div, F3Rem, F3Divu, F3Remu, F3Div, F3Rem, F3Div, F3Rem, F3Divu};
        logic [31:0] va [9] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] vb [9] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ex [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
        int          el [9] = '{33, 33, 33, 33, 1, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            run32(f3[i], va[i], vb[i], 5'(i + 10), res, rtag, lat);
            total++; if (res !== ex[i]) begin bad++; $display("FAIL div32[%0d] result got %h want %h", i, res, ex[i]); end
            total++; if (rtag !== 5'(i + 10)) begin bad++; $display("FAIL div32[%0d] tag got %0d want %0d", i, rtag, i + 10); end
            total++; if (lat != el[i]) begin bad++; $display("FAIL div32[%0d] latency got %0d want %0d", i, lat, el[i]); end
        end
    endtask

    task automatic test_stall;
        int n = 0;
        @(negedge clk);
        in_valid32 = 1; in_funct3_32 = F3Mul; in_a32 = 32'd3; in_b32 = 32'd5; in_tag32 = 5'd9;
        @(posedge clk); #1;
        in_valid32 = 0;
        while (out_valid32 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n >= 100) begin bad++; $display("FAIL stall_wait got timeout want out_valid"); end
        // A competing request while DONE must not be taken.
        in_valid32 = 1; in_funct3_32 = F3Divu; in_a32 = 32'd1; in_b32 = 32'd1; in_tag32 = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid32 !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, out_valid32); end
            total++; if (out_result32 !== 32'd15) begin bad++; $display("FAIL stall_result[%0d] got %h want f", i, out_result32); end
            total++; if (out_tag32 !== 5'd9) begin bad++; $display("FAIL stall_tag[%0d] got %0d want 9", i, out_tag32); end
            total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready32); end
        end
        in_valid32 = 0;
        @(negedge clk); out_ready32 = 1;
        @(posedge clk); #1; out_ready32 = 0;
        total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL stall_release_ready got %b want 1", in_ready32); end
        total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL stall_release_valid got %b want 0", out_valid32); end
    endtask

    task automatic test_flush;
        logic        seen = 0;
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        @(negedge clk);
        in_valid32 = 1; in_funct3_32 = F3Mul; in_a32 = 32'd7; in_b32 = 32'd9; in_tag32 = 5'd4;
        @(posedge clk); #1;
        in_valid32 = 0;
        repeat (5) @(posedge clk);
        @(negedge clk); flush32 = 1;
        @(posedge clk); #1; flush32 = 0;
        total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b want 1", in_ready32); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1; seen |= out_valid32;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_result got %b want 0", seen); end
        // Flush together with a request in IDLE: the request is dropped.
        @(negedge clk); flush32 = 1; in_valid32 = 1; in_funct3_32 = F3Divu; in_b32 = 32'd0;
        @(posedge clk); #1; flush32 = 0; in_valid32 = 0;
        total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL flush_vs_accept got %b want 1", in_ready32); end
        run32(F3Divu, 32'd100, 32'd7, 5'd6, res, rtag, lat);
        total++; if (res !== 32'd14) begin bad++; $display("FAIL flush_after result got %h want e", res); end
        total++; if (lat != 33) begin bad++; $display("FAIL flush_after latency got %0d want 33", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic [4:0]  rtag;
        int          lat;
        @(negedge clk);
        in_valid32 = 1; in_funct3_32 = F3Mul; in_a32 = 32'd3; in_b32 = 32'd5; in_tag32 = 5'd2;
        @(posedge clk); #1;
        in_valid32 = 0;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", out_valid32); end
        total++; if (out_result32 !== 32'h0) begin bad++; $display("FAIL rst_mid_result got %h want 0", out_result32); end
        total++; if (out_tag32 !== 5'h0) begin bad++; $display("FAIL rst_mid_tag got %h want 0", out_tag32); end
        @(posedge clk); #2 rst_n = 1;
        #1;
        total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got %b want 1", in_ready32); end
        run32(F3Mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, res, rtag, lat);
        total++; if (res !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rst_mid_after result got %h want fffffffe", res); end
        total++; if (rtag !== 5'd7) begin bad++; $display("FAIL rst_mid_after tag got %0d want 7", rtag); end
        total++; if (lat != 33) begin bad++; $display("FAIL rst_mid_after latency got %0d want 33", lat); end
    endtask

    task automatic test_w64;
        logic [2:0]  f3 [8] = '{F3Div, F3Mul, F3Mul, F3Divu, F3Rem, F3Mulhu, F3Div, F3Div};
        logic        w  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] va [8] = '{64'h0000_0000_FFFF_FFF9, 64'h0000_0001_0000_0001,
                                64'h0000_0000_7FFF_FFFF, 64'h1234_5678_FFFF_FFFF,
                                64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000};
        logic [63:0] vb [8] = '{64'd2, 64'd3, 64'd2, 64'hABCD_0000_0000_0001, 64'h5555_0000_0000_0000,
                                64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        logic [63:0] ex [8] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0003_0000_0003,
                                64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FFF9, 64'h1,
                                64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
        int          el [8] = '{33, 65, 33, 33, 1, 65, 1, 1};
        logic [63:0] res;
        logic [4:0]  rtag;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run64(f3[i], w[i], va[i], vb[i], 5'(i + 20), res, rtag, lat);
            total++; if (res !== ex[i]) begin bad++; $display("FAIL x64[%0d] result got %h want %h", i, res, ex[i]); end
            total++; if (rtag !== 5'(i + 20)) begin bad++; $display("FAIL x64[%0d] tag got %0d want %0d", i, rtag, i + 20); end
            total++; if (lat != el[i]) begin bad++; $display("FAIL x64[%0d] latency got %0d want %0d", i, lat, el[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_stall;
        test_flush;
        test_reset_mid;
        test_w64;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
